// File: rtl/usfft64_stream_ctrl.sv
// Stream controller for the USFFT64 core: takes one 64-sample frame from a
// valid/ready stream, drives load/flush/unload and re-emits the results.
module usfft64_stream_ctrl #(
    parameter int unsigned IW  = 16,
    parameter int unsigned OW  = 19,
    parameter int unsigned TMO = 1023
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [IW-1:0] s_re,
    input  logic [IW-1:0] s_im,
    input  logic [3:0]    cfg_shift,
    output logic          fft_start,
    output logic          fft_ed,
    output logic [3:0]    fft_shift,
    output logic [IW-1:0] fft_dr,
    output logic [IW-1:0] fft_di,
    input  logic          fft_rdy,
    input  logic [5:0]    fft_addr,
    input  logic [OW-1:0] fft_dor,
    input  logic [OW-1:0] fft_doi,
    input  logic          fft_ovf1,
    input  logic          fft_ovf2,
    output logic          m_valid,
    output logic [OW-1:0] m_re,
    output logic [OW-1:0] m_im,
    output logic [5:0]    m_idx,
    output logic          m_last,
    output logic [1:0]    ovf,
    output logic          addr_err,
    output logic          tmo_err,
    output logic          busy
);
    localparam int unsigned CW = 6;
    localparam int unsigned TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, START, LOAD, FLUSH, OUT} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo_cnt;
    logic          accept;
    logic          capture;
    logic          timeout;

    // Next state and per-cycle strobes; s_ready depends on state only.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            IDLE: begin
                if (s_valid) state_next = START;
            end
            START: state_next = LOAD;
            LOAD: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid && cnt == CW'(63)) state_next = FLUSH;
            end
            FLUSH: begin
                // A result on the last allowed cycle still wins over the timeout.
                if (fft_rdy) begin
                    capture    = 1'b1;
                    state_next = OUT;
                end else if (tmo_cnt == TW'(TMO - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            OUT: begin
                capture = 1'b1;
                if (cnt == CW'(63)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Registered core drive, result capture and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fft_start <= 1'b0;
            fft_ed    <= 1'b0;
            fft_shift <= 4'd0;
            fft_dr    <= '0;
            fft_di    <= '0;
            cnt       <= '0;
            tmo_cnt   <= '0;
            m_valid   <= 1'b0;
            m_re      <= '0;
            m_im      <= '0;
            m_idx     <= '0;
            m_last    <= 1'b0;
            ovf       <= 2'b00;
            addr_err  <= 1'b0;
            tmo_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fft_start <= (state_next == START);
            fft_ed    <= accept || (state == FLUSH) || (state == OUT);
            fft_dr    <= accept ? s_re : '0;
            fft_di    <= accept ? s_im : '0;
            busy      <= (state_next != IDLE);
            m_valid   <= capture;
            m_last    <= capture && (cnt == CW'(63));
            tmo_cnt   <= (state == FLUSH) ? tmo_cnt + TW'(1) : '0;

            if (state == START) begin
                fft_shift <= cfg_shift;
                ovf       <= 2'b00;
                cnt       <= '0;
            end else if (accept || capture) begin
                cnt <= cnt + CW'(1);
            end

            if (capture) begin
                m_re  <= fft_dor;
                m_im  <= fft_doi;
                m_idx <= cnt;
                ovf   <= ovf | {fft_ovf2, fft_ovf1};
                if (fft_addr != cnt) addr_err <= 1'b1;
            end

            if (timeout) tmo_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_usfft64_stream_ctrl.sv
// Bench for usfft64_stream_ctrl: behavioural USFFT64 core model, directed
// frames, and a scoreboard monitor on the result stream.
`timescale 1ns/1ps
module tb_usfft64_stream_ctrl;
    localparam int unsigned IW  = 16;
    localparam int unsigned OW  = 19;
    localparam int unsigned TMO = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] s_re;
    logic [IW-1:0] s_im;
    logic [3:0]    cfg_shift;
    logic          fft_start;
    logic          fft_ed;
    logic [3:0]    fft_shift;
    logic [IW-1:0] fft_dr;
    logic [IW-1:0] fft_di;
    logic          fft_rdy  = 1'b0;
    logic [5:0]    fft_addr = '0;
    logic [OW-1:0] fft_dor  = '0;
    logic [OW-1:0] fft_doi  = '0;
    logic          fft_ovf1 = 1'b0;
    logic          fft_ovf2 = 1'b0;
    logic          m_valid;
    logic [OW-1:0] m_re;
    logic [OW-1:0] m_im;
    logic [5:0]    m_idx;
    logic          m_last;
    logic [1:0]    ovf;
    logic          addr_err;
    logic          tmo_err;
    logic          busy;

    usfft64_stream_ctrl #(.IW(IW), .OW(OW), .TMO(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .cfg_shift(cfg_shift),
        .fft_start(fft_start), .fft_ed(fft_ed), .fft_shift(fft_shift),
        .fft_dr(fft_dr), .fft_di(fft_di),
        .fft_rdy(fft_rdy), .fft_addr(fft_addr), .fft_dor(fft_dor), .fft_doi(fft_doi),
        .fft_ovf1(fft_ovf1), .fft_ovf2(fft_ovf2),
        .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_idx(m_idx), .m_last(m_last),
        .ovf(ovf), .addr_err(addr_err), .tmo_err(tmo_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]    idx;
        logic [OW-1:0] re;
        logic [OW-1:0] im;
        logic          last;
        logic [1:0]    ovf;
        logic          aerr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   aerr_base = 1'b0;

    // Core model controls and observations.
    int            phase = 3;
    int            ld = 0;
    int            k = 0;
    int            wt = 0;
    int            rdy_delay = 10;
    int            t_rdy = 0;
    int            start_cnt = 0;
    int            tmo_wt = -1;
    bit            swap56 = 1'b0;
    bit            ovf_pat = 1'b0;
    bit            stray_req = 1'b0;
    logic [IW-1:0] mem_re [64];
    logic [IW-1:0] mem_im [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Core model: records ED samples, pulses RDY after a delay, then streams results.
    always @(negedge CLK) begin
        int p;
        bit drv;
        drv = 1'b0;
        p   = 0;
        if (RST) begin
            phase = 3; ld = 0; fft_rdy = 1'b0; fft_ovf1 = 1'b0; fft_ovf2 = 1'b0;
        end else begin
            fft_rdy = 1'b0; fft_ovf1 = 1'b0; fft_ovf2 = 1'b0;
            if (fft_start) begin
                phase = 0; ld = 0; start_cnt++;
            end
            case (phase)
                0: if (fft_ed) begin
                    mem_re[ld] = fft_dr;
                    mem_im[ld] = fft_di;
                    ld++;
                    if (ld == 64) begin phase = 1; wt = 0; end
                end
                1: begin
                    wt++;
                    if (tmo_err && tmo_wt < 0) tmo_wt = wt;
                    if (wt == rdy_delay) begin
                        fft_rdy = 1'b1; t_rdy = cyc; drv = 1'b1; p = 0; k = 1; phase = 2;
                    end
                end
                2: begin
                    drv = 1'b1; p = k; k++;
                    if (k == 64) phase = 3;
                end
                default: if (stray_req) begin
                    fft_rdy = 1'b1; fft_addr = 6'd5; stray_req = 1'b0;
                end
            endcase
            if (drv) begin
                fft_addr = (swap56 && p == 5) ? 6'd6 : (swap56 && p == 6) ? 6'd5 : 6'(p);
                fft_dor  = {3'b101, mem_re[p]};
                fft_doi  = {3'b110, mem_im[p]};
                fft_ovf1 = ovf_pat && (p == 10);
                fft_ovf2 = ovf_pat && (p == 40);
            end
        end
    end

    // Scoreboard monitor on the result stream.
    always @(negedge CLK) begin
        exp_t e;
        if (m_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_m_valid: got m_idx=%0d with no result expected (cycle %0d)", m_idx, cyc);
            end else begin
                e = sb.pop_front();
                chk("m_idx",    64'(m_idx),    64'(e.idx));
                chk("m_re",     64'(m_re),     64'(e.re));
                chk("m_im",     64'(m_im),     64'(e.im));
                chk("m_last",   64'(m_last),   64'(e.last));
                chk("ovf",      64'(ovf),      64'(e.ovf));
                chk("addr_err", 64'(addr_err), 64'(e.aerr));
                chk("latency",  64'(cyc - t_rdy), 64'(1 + int'(e.idx)));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_core_if"}, 64'({s_ready, fft_start, fft_ed, fft_shift, fft_dr, fft_di}), 64'(0));
        chk({tag, "_stream"},  64'({m_valid, m_re, m_im, m_idx, m_last}), 64'(0));
        chk({tag, "_flags"},   64'({ovf, addr_err, tmo_err, busy}), 64'(0));
    endtask

    task automatic send_frame(input int f, input bit gap, input int abort_at, input bit expect_out);
        exp_t fe [64];
        int n = 0;
        int t = 0;
        while (n < 64 && t < 400) begin
            @(negedge CLK);
            if (abort_at >= 0 && n == abort_at) break;
            s_valid = !(gap && (t % 3 == 2));
            s_re    = IW'(f * 256 + n);
            s_im    = IW'(49152 + f * 64 + n);
            if (s_valid && s_ready) begin
                if (n == 0) chk("ovf_clear_after_start", 64'(ovf), 64'(0));
                fe[n].idx  = 6'(n);
                fe[n].re   = {3'b101, s_re};
                fe[n].im   = {3'b110, s_im};
                fe[n].last = (n == 63);
                fe[n].ovf  = ovf_pat ? {n >= 40, n >= 10} : 2'b00;
                fe[n].aerr = aerr_base || (swap56 && n >= 5);
                n++;
            end
            t++;
        end
        if (abort_at >= 0) begin
            RST = 1'b1;
            s_valid = 1'b0;
            @(negedge CLK);
            check_reset_outputs("mid_frame_reset");
            RST = 1'b0;
            aerr_base = 1'b0;
        end else begin
            chk("load_accepts", 64'(n), 64'(64));
            if (expect_out) for (int i = 0; i < 64; i++) sb.push_back(fe[i]);
            aerr_base = aerr_base || swap56;
            @(negedge CLK);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 400) begin
            @(negedge CLK);
            g++;
        end
        checks++;
        if (g >= 400) begin
            failures++;
            $display("FAIL frame_done_timeout: got %0d results pending, busy=%0b, expected 0 and 0", sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic run_frame(input int f, input bit gap, input int delay, input bit ovfp,
                             input bit sw, input int abort_at);
        logic [3:0] sh;
        sh = 4'(f + 3);
        rdy_delay = delay;
        ovf_pat   = ovfp;
        swap56    = sw;
        start_cnt = 0;
        cfg_shift = sh;
        send_frame(f, gap, abort_at, delay >= 0);
        if (abort_at < 0) begin
            wait_done();
            chk("start_pulses",  64'(start_cnt), 64'(1));
            chk("ed_load_beats", 64'(ld), 64'(64));
            chk("fft_shift",     64'(fft_shift), 64'(sh));
            repeat (2) @(negedge CLK);
        end
    endtask

    initial begin
        RST = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; cfg_shift = 4'h9;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        run_frame(1, 1'b0, 10, 1'b0, 1'b0, -1);   // continuous input
        run_frame(2, 1'b1, 14, 1'b0, 1'b0, -1);   // gaps; RDY on the last allowed FLUSH cycle
        run_frame(3, 1'b0, 10, 1'b1, 1'b0, -1);   // overflow flags at 10 and 40
        run_frame(4, 1'b0, 10, 1'b0, 1'b0, -1);   // clean frame after overflow

        stray_req = 1'b1;                         // RDY while idle must be ignored
        repeat (5) @(negedge CLK);
        chk("stray_rdy_addr_err", 64'(addr_err), 64'(0));
        chk("stray_rdy_busy",     64'(busy),     64'(0));

        run_frame(5, 1'b0, 10, 1'b0, 1'b1, -1);   // ADDR 5/6 swapped
        run_frame(6, 1'b1, 10, 1'b0, 1'b0, -1);   // addr_err stays set

        tmo_wt = -1;
        run_frame(7, 1'b0, -1, 1'b0, 1'b0, -1);   // core never answers
        chk("tmo_flush_cycles", 64'(tmo_wt), 64'(TMO));
        chk("tmo_err_set",      64'(tmo_err), 64'(1));
        chk("tmo_busy_low",     64'(busy), 64'(0));

        run_frame(8, 1'b0, 12, 1'b0, 1'b0, -1);   // recovers after timeout
        chk("tmo_err_sticky",   64'(tmo_err), 64'(1));

        run_frame(9, 1'b0, 10, 1'b0, 1'b0, 30);   // reset after 30 load samples
        repeat (2) @(negedge CLK);
        run_frame(10, 1'b0, 10, 1'b1, 1'b0, -1);  // fresh frame after reset
        chk("post_reset_addr_err", 64'(addr_err), 64'(0));
        chk("post_reset_tmo_err",  64'(tmo_err),  64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
